// File: rtl/riv_timer_pkg.sv
// Shared types and constants for the riv_timer sequencing controller.
package riv_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_PAUSE = 2'd3
   } riv_timer_state_t;

   localparam int RIV_TIMER_EXPIRE_CNT_WIDTH = 8;
   localparam logic [RIV_TIMER_EXPIRE_CNT_WIDTH-1:0] RIV_TIMER_EXPIRE_CNT_ONE =
      {{(RIV_TIMER_EXPIRE_CNT_WIDTH-1){1'b0}}, 1'b1};

   // Saturating increment used by the expiry counter.
   function automatic logic [RIV_TIMER_EXPIRE_CNT_WIDTH-1:0] riv_sat_inc(
      input logic [RIV_TIMER_EXPIRE_CNT_WIDTH-1:0] v
   );
      if (&v) begin
         return v;
      end else begin
         return v + RIV_TIMER_EXPIRE_CNT_ONE;
      end
   endfunction

endpackage

// File: rtl/riv_timer_prescaler.sv
// Prescale down counter: clear loads the reload value, tick fires at zero while enabled,
// and the count reloads on each tick so ticks repeat every reload_value+1 enabled cycles.
module riv_timer_prescaler
   import riv_timer_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      enable,
   input  logic [PRESCALE_WIDTH-1:0] reload_value,
   output logic                      tick
);

   localparam logic [PRESCALE_WIDTH-1:0] PS_ZERO = {PRESCALE_WIDTH{1'b0}};
   localparam logic [PRESCALE_WIDTH-1:0] PS_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

   logic [PRESCALE_WIDTH-1:0] count_q;
   logic [PRESCALE_WIDTH-1:0] count_d;

   assign tick = enable & (count_q == PS_ZERO);

   // Next prescale count: clear has priority, otherwise count down and reload on tick.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = reload_value;
      end else if (enable) begin
         if (count_q == PS_ZERO) begin
            count_d = reload_value;
         end else begin
            count_d = count_q - PS_ONE;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Prescale count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= PS_ZERO;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/riv_timer_ctrl.sv
// Timer sequencing controller driving an external down counter (load/enable/done).
// Define RIV_TIMER_CTRL_EXPIRE_CNT_EN to add the saturating expire_count output.
module riv_timer_ctrl
   import riv_timer_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          period,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      periodic,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      pause,
   output logic                      busy,
   output logic                      expired,
   output logic [WIDTH-1:0]          cnt_value,
   output logic                      cnt_load,
   output logic                      cnt_enable,
   input  logic                      cnt_done
`ifdef RIV_TIMER_CTRL_EXPIRE_CNT_EN
   ,
   output logic [RIV_TIMER_EXPIRE_CNT_WIDTH-1:0] expire_count
`endif
);

   riv_timer_state_t          state_q;
   riv_timer_state_t          state_d;
   logic [WIDTH-1:0]          period_q;
   logic [PRESCALE_WIDTH-1:0] prescale_q;
   logic                      periodic_q;
   logic                      busy_q;
   logic                      cnt_load_q;
   logic                      latch_s;
   logic                      tick_s;
   logic                      in_run_s;
   logic                      in_load_s;
   logic                      abort_s;

   assign in_run_s  = (state_q == ST_RUN);
   assign in_load_s = (state_q == ST_LOAD);
   assign abort_s   = stop | rst;

   // An abort in the expiry cycle must swallow the pulse and keep the counter frozen.
   assign expired    = in_run_s & cnt_done & ~abort_s;
   assign cnt_enable = in_run_s & tick_s & ~cnt_done & ~abort_s;

   assign busy      = busy_q;
   assign cnt_load  = cnt_load_q;
   assign cnt_value = period_q;

   riv_timer_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk          (clk),
      .rst          (rst),
      .clear        (in_load_s),
      .enable       (in_run_s),
      .reload_value (prescale_q),
      .tick         (tick_s)
   );

   // Next-state decode; in RUN the order is stop, expiry, start, pause.
   always_comb begin
      state_d = state_q;
      latch_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start & ~stop) begin
               state_d = ST_LOAD;
               latch_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_LOAD;
               latch_s = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cnt_done) begin
               if (start) begin
                  state_d = ST_LOAD;
                  latch_s = 1'b1;
               end else if (periodic_q) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (start) begin
               state_d = ST_LOAD;
               latch_s = 1'b1;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_LOAD;
               latch_s = 1'b1;
            end else if (~pause) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched configuration and state-decoded outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         period_q   <= {WIDTH{1'b0}};
         prescale_q <= {PRESCALE_WIDTH{1'b0}};
         periodic_q <= 1'b0;
         busy_q     <= 1'b0;
         cnt_load_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= (state_d != ST_IDLE);
         cnt_load_q <= (state_d == ST_LOAD);
         if (latch_s) begin
            period_q   <= period;
            prescale_q <= prescale;
            periodic_q <= periodic;
         end
      end
   end

`ifdef RIV_TIMER_CTRL_EXPIRE_CNT_EN
   logic [RIV_TIMER_EXPIRE_CNT_WIDTH-1:0] expire_cnt_q;
   logic [RIV_TIMER_EXPIRE_CNT_WIDTH-1:0] expire_cnt_d;

   assign expire_count = expire_cnt_q;

   // A restart clears the tally even if it coincides with an expiry.
   always_comb begin
      expire_cnt_d = expire_cnt_q;
      if (latch_s) begin
         expire_cnt_d = {RIV_TIMER_EXPIRE_CNT_WIDTH{1'b0}};
      end else if (expired) begin
         expire_cnt_d = riv_sat_inc(expire_cnt_q);
      end else begin
         expire_cnt_d = expire_cnt_q;
      end
   end

   // Expiry tally register.
   always_ff @(posedge clk) begin
      if (rst) begin
         expire_cnt_q <= {RIV_TIMER_EXPIRE_CNT_WIDTH{1'b0}};
      end else begin
         expire_cnt_q <= expire_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_riv_timer_ctrl.sv
// Self-checking bench for riv_timer_ctrl with an attached down-counter model.
module tb_riv_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] period = 16'd0;
   logic [7:0]  prescale = 8'd0;
   logic        periodic = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        pause = 1'b0;
   logic        busy, expired, cnt_load, cnt_enable, cnt_done;
   logic [15:0] cnt_value;
`ifdef RIV_TIMER_CTRL_EXPIRE_CNT_EN
   logic [7:0]  expire_count;
`endif

   always #5 clk = ~clk;

   riv_timer_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .period     (period),
      .prescale   (prescale),
      .periodic   (periodic),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .busy       (busy),
      .expired    (expired),
      .cnt_value  (cnt_value),
      .cnt_load   (cnt_load),
      .cnt_enable (cnt_enable),
      .cnt_done   (cnt_done)
`ifdef RIV_TIMER_CTRL_EXPIRE_CNT_EN
      ,
      .expire_count (expire_count)
`endif
   );

   // Attached down counter (never reset, starts with stale contents)
   logic [15:0] ctr_q = 16'd9;
   assign cnt_done = (ctr_q == 16'd0);
   always @(posedge clk) begin
      if (cnt_load) ctr_q <= cnt_value;
      else if (cnt_enable) ctr_q <= ctr_q - 16'd1;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int en_cnt  = 0;
   int exp_q[$];

   // Reference model: run-cycle budget derived from period*(prescale+1)
   bit m_active = 0, m_loading = 0, m_paused = 0, m_per = 0;
   int m_runs = 0, m_n = 0, m_p = 0, m_cnt = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input bit rs, input bit st, input bit sp, input bit ps,
                       input bit pr, input int per, input int pre);
      bit eff, run, e_exp, e_en;
      int k;
      @(negedge clk);
      rst = rs; start = st; stop = sp; pause = ps; periodic = pr;
      period = per[15:0]; prescale = pre[7:0];
      #1;
      eff   = rs | sp;
      run   = m_active & !m_loading & !m_paused;
      e_exp = run && (m_runs == 0) && !eff;
      k     = m_n * (m_p + 1) - m_runs;
      e_en  = run && (m_runs > 0) && (((k + 1) % (m_p + 1)) == 0) && !eff;
      check("busy", int'(busy), int'(m_active));
      check("cnt_load", int'(cnt_load), int'(m_active & m_loading));
      check("expired", int'(expired), int'(e_exp));
      check("cnt_enable", int'(cnt_enable), int'(e_en));
      check("cnt_value", int'(cnt_value), m_n);
      if (cnt_done) check("enable_while_done", int'(cnt_enable), 0);
`ifdef RIV_TIMER_CTRL_EXPIRE_CNT_EN
      check("expire_count", int'(expire_count), m_cnt);
`endif
      if (expired) exp_q.push_back(cyc);
      if (cnt_enable) en_cnt++;
      if (rs) begin
         m_active = 0; m_loading = 0; m_paused = 0;
         m_n = 0; m_p = 0; m_per = 0; m_cnt = 0; m_runs = 0;
      end else if (sp) begin
         m_active = 0;
      end else begin
         if (e_exp && m_cnt < 255) m_cnt++;
         if (st) begin
            m_n = per; m_p = pre; m_per = pr; m_cnt = 0;
            m_active = 1; m_loading = 1; m_paused = 0;
         end else if (!m_active) begin
            m_active = 0;
         end else if (m_loading) begin
            m_loading = 0;
            m_runs = m_n * (m_p + 1);
         end else if (m_paused) begin
            if (!ps) m_paused = 0;
         end else if (m_runs == 0) begin
            if (m_per) m_loading = 1;
            else m_active = 0;
         end else begin
            m_runs--;
            if (ps) m_paused = 1;
         end
      end
      cyc++;
   endtask

   typedef struct {
      int period; int prescale; bit periodic;
      int pause_lo; int pause_hi; int stop_cyc; int restart_cyc; int window;
      int exp_n; int e0; int e1; int e2; int exp_en;
   } vec_t;

   vec_t tv[7];

   initial begin
      // period, prescale, periodic, pause_lo..hi, stop, restart, window, n, e0..e2, enables
      tv[0] = '{3, 0, 1'b0, -1, -1, -1, -1, 12, 1,  5, -1, -1, 3};
      tv[1] = '{2, 2, 1'b1, -1, -1, 26, -1, 27, 3,  8, 16, 24, 6};
      tv[2] = '{0, 3, 1'b0, -1, -1, -1, -1,  8, 1,  2, -1, -1, 0};
      tv[3] = '{4, 0, 1'b0,  3,  5, -1, -1, 14, 1,  9, -1, -1, 4};
      tv[4] = '{4, 1, 1'b0, -1, -1, 10, -1, 14, 0, -1, -1, -1, 4};
      tv[5] = '{5, 0, 1'b0, -1, -1, -1,  4, 14, 1, 11, -1, -1, 8};
      tv[6] = '{3, 1, 1'b0, -1, -1, -1,  8, 20, 2,  8, 16, -1, 6};

      repeat (2) @(posedge clk);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

      for (int t = 0; t < 7; t++) begin
         cyc = 0; en_cnt = 0; exp_q.delete();
         for (int c = 0; c < tv[t].window; c++) begin
            step(1'b0, (c == 0) || (c == tv[t].restart_cyc), c == tv[t].stop_cyc,
                 (c >= tv[t].pause_lo) && (c <= tv[t].pause_hi),
                 tv[t].periodic, tv[t].period, tv[t].prescale);
         end
         check($sformatf("vec%0d_num_expiries", t), exp_q.size(), tv[t].exp_n);
         check($sformatf("vec%0d_enables", t), en_cnt, tv[t].exp_en);
         for (int i = 0; i < tv[t].exp_n && i < 3; i++) begin
            int want;
            want = (i == 0) ? tv[t].e0 : ((i == 1) ? tv[t].e1 : tv[t].e2);
            check($sformatf("vec%0d_expiry%0d_cycle", t, i),
                  (i < exp_q.size()) ? exp_q[i] : -1, want);
         end
         repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      end

      // Mid-operation reset aborts without a pulse
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

`ifdef RIV_TIMER_CTRL_EXPIRE_CNT_EN
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
      repeat (620) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("expire_count_saturated", int'(expire_count), 255);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("expire_count_cleared", int'(expire_count), 0);
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
`endif

      // Randomized traffic against the reference model
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(999, 0) < 3, $urandom_range(99, 0) < 4,
              $urandom_range(99, 0) < 1, $urandom_range(99, 0) < 20,
              $urandom_range(1, 0) == 1, int'($urandom_range(6, 0)),
              int'($urandom_range(3, 0)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
